// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over XLEN cycles, tagged valid/ready I/O.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module riscv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t              state, state_next;
    logic [2:0]          op_q;
    logic [TAG_W-1:0]    tag_q;
    logic                neg_q;
    logic [CW-1:0]       count_q;
    logic [2*XLEN-1:0]   work_q;
    logic [XLEN-1:0]     opnd_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                sign_a, sign_b, b_zero, neg_in;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                early_hit;
    logic [XLEN-1:0]     early_result;

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign out_result = result_q;
    assign out_tag    = tag_q;
    assign accept     = in_valid && in_ready && !flush;

    // Work on magnitudes; the sign is reapplied once the iteration finishes.
    assign sign_a = in_a[XLEN-1] && (in_op == OP_MULH || in_op == OP_MULHSU ||
                                     in_op == OP_DIV  || in_op == OP_REM);
    assign sign_b = in_b[XLEN-1] && (in_op == OP_MULH || in_op == OP_DIV || in_op == OP_REM);
    assign a_mag  = sign_a ? -in_a : in_a;
    assign b_mag  = sign_b ? -in_b : in_b;
    assign b_zero = (in_b == '0);
    // Remainder follows the dividend; a zero divisor must leave the all-ones quotient unnegated.
    assign neg_in = (in_op[2] && in_op[1]) ? sign_a : ((sign_a ^ sign_b) && !(in_op[2] && b_zero));

`ifdef MULDIV_EARLY_OUT_EN
    logic div_ovf;
    assign div_ovf   = (in_op == OP_DIV || in_op == OP_REM) &&
                       (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
    assign early_hit = in_op[2] ? (b_zero || div_ovf) : ((in_a == '0) || b_zero);
    always_comb begin
        early_result = '0;
        if (in_op[2] && b_zero)
            early_result = in_op[1] ? in_a : '1;
        else if (div_ovf)
            early_result = in_op[1] ? '0 : in_a;
    end
`else
    assign early_hit    = 1'b0;
    assign early_result = '0;
`endif

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] mul_next, div_next, work_next, mul_fixed;
    logic [XLEN-1:0]   div_sel, final_result;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, work_q[XLEN-1:1]};
        div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = !div_diff[XLEN];
        div_next  = {div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], work_q[XLEN-2:0], div_ok};
        work_next = op_q[2] ? div_next : mul_next;
        mul_fixed = neg_q ? -mul_next : mul_next;
        div_sel   = op_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        if (op_q[2])
            final_result = neg_q ? -div_sel : div_sel;
        else if (op_q[1:0] == 2'd0)
            final_result = mul_fixed[XLEN-1:0];
        else
            final_result = mul_fixed[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_next = early_hit ? S_DONE : S_BUSY;
                S_BUSY:  if (count_q == LAST) state_next = S_DONE;
                S_DONE:  if (out_ready) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= in_op;
            tag_q   <= in_tag;
            neg_q   <= neg_in;
            count_q <= '0;
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
            work_q  <= {{XLEN{1'b0}}, in_op[2] ? a_mag : b_mag};
            opnd_q  <= in_op[2] ? b_mag : a_mag;
            if (early_hit)
                result_q <= early_result;
        end else if (state == S_BUSY && !flush) begin
            work_q  <= work_next;
            count_q <= count_q + 1'b1;
            if (count_q == LAST)
                result_q <= final_result;
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: directed RV32M corner cases, random ops, backpressure, flush, reset.
module tb_riscv_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [XLEN-1:0]  in_a = '0;
    logic [XLEN-1:0]  in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, up;
        longint      sa, sb_, sp;
        logic        ovf;
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = '0;
        case (op)
            3'd0: begin up = ua * ub;            model = up[31:0];  end
            3'd1: begin sp = sa * sb_;           model = sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub);  model = sp[63:32]; end
            3'd3: begin up = ua * ub;            model = up[63:32]; end
            3'd4: begin
                if (b == 0)   model = 32'hFFFF_FFFF;
                else if (ovf) model = a;
                else begin sp = sa / sb_; model = sp[31:0]; end
            end
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)   model = a;
                else if (ovf) model = 32'h0;
                else begin sp = sa % sb_; model = sp[31:0]; end
            end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic hit;
        if (op[2])
            hit = (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else
            hit = (a == 0) || (b == 0);
        return hit ? 0 : XLEN;
`else
        return XLEN;
`endif
    endfunction

    // Presents one request, waits for the accept edge, then scrambles the operand inputs.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 100) begin @(posedge clock); #1; n++; end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = 5'($urandom);
        e.res = exp;
        e.tag = tag;
        e.lat = exp_latency(op, a, b);
        sb.push_back(e);
    endtask

    // Waits for the result (bounded), optionally stalls it for `hold` cycles, then accepts it.
    task automatic collect(input string name, input int hold);
        exp_t e;
        int   n = 0;
        e.res = '0; e.tag = '0; e.lat = -1;
        out_ready = (hold == 0);
        while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
        if (sb.size() != 0) e = sb.pop_front();
        check({name, ".latency"}, n, e.lat);
        check({name, ".result"}, out_result, e.res);
        check({name, ".tag"}, out_tag, e.tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check($sformatf("%s.hold%0d.valid", name, i), out_valid, 1);
            check($sformatf("%s.hold%0d.result", name, i), out_result, e.res);
            check($sformatf("%s.hold%0d.tag", name, i), out_tag, e.tag);
            check($sformatf("%s.hold%0d.in_ready", name, i), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check({name, ".released"}, out_valid, 0);
        check({name, ".ready_again"}, in_ready, 1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF},
        '{3'd5, 32'd100,        32'd0,          32'hFFFF_FFFF},
        '{3'd7, 32'd100,        32'd0,          32'd100},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF},
        '{3'd6, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9},
        '{3'd0, 32'd0,          32'd12345,      32'd0},
        '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
        '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd1, 32'hFFFF_FFFF, 32'd3,          32'hFFFF_FFFF}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          seen;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.busy", busy, 0);
        check("reset.out_result", out_result, 0);
        check("reset.out_tag", out_tag, 0);

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);
            collect($sformatf("dir%0d", i), 0);
        end

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 4 == 3) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 3 == 1) ra = ra >> $urandom_range(0, 31);
            issue(rop, ra, rb, 5'(i + 17), model(rop, ra, rb));
            collect($sformatf("rnd%0d", i), 0);
        end

        issue(3'd5, 32'd1000, 32'd7, 5'd9, 32'd142);
        collect("stall", 5);

        issue(3'd0, 32'd3, 32'd5, 5'd3, 32'd15);
        repeat (9) begin @(posedge clock); #1; end
        check("flush.busy_before", busy, 1);
        check("flush.in_ready_before", in_ready, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd5;
        in_a     = 32'd9;
        in_b     = 32'd3;
        in_tag   = 5'd4;
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        check("flush.busy_after", busy, 0);
        check("flush.out_valid_after", out_valid, 0);
        check("flush.in_ready_after", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("flush.no_result", seen, 0);
        issue(3'd5, 32'd9, 32'd3, 5'd4, 32'd3);
        collect("post_flush", 0);

        issue(3'd5, 32'd9, 32'd3, 5'd6, 32'd3);
        repeat (9) begin @(posedge clock); #1; end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_mid.in_ready", in_ready, 1);
        check("rst_mid.out_valid", out_valid, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.out_result", out_result, 0);
        check("rst_mid.out_tag", out_tag, 0);
        @(negedge clock);
        reset_n = 1'b1;
        sb.delete();
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("rst_mid.no_result", seen, 0);

        issue(3'd7, 32'd100, 32'd7, 5'd2, 32'd2);
        collect("post_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
